// File: rtl/serial_tx_scheduler_if.sv
// Purpose : requester-side byte handshake plus serial lane outputs of serial_tx_scheduler.
// Latency : n/a (signal bundle only).
// Backpressure: req_ready is the only backpressure; requesters hold req_valid/req_data until accepted.
// Ports   : req_valid/req_data/req_ready (byte handshake), serialOut/bit_valid/frame_start/
//           frame_src/busy (serial lane status). master = requester/observer side, slave = scheduler.
interface serial_tx_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) ();
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      serialOut;
  logic                      bit_valid;
  logic                      frame_start;
  logic [SRC_W-1:0]          frame_src;
  logic                      busy;

  modport master (
    output req_valid, req_data,
    input  req_ready, serialOut, bit_valid, frame_start, frame_src, busy
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, serialOut, bit_valid, frame_start, frame_src, busy
  );
endinterface

// File: rtl/serial_tx_scheduler.sv
// Purpose : round-robin arbiter feeding one LSB-first serializer from NUM_REQ byte requesters.
// Latency : grant at edge T puts bit k on serialOut during cycle T+k; frame period DATA_W+1+IDLE_GAP.
// Backpressure: req_ready only in IDLE, one-hot to the round-robin winner; nothing is buffered.
// Ports   : clock, reset_n (async active-low); bus (slave modport) carries the per-requester
//           valid/data/ready handshake and the registered serial lane outputs.
module serial_tx_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int IDLE_GAP = 0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  serial_tx_scheduler_if.slave    bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PTR_W-1:0]    r_ptr;
  logic [CNT_W-1:0]    r_cnt;
  logic [3:0]          r_gap_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic                r_so;
  logic                r_bv;
  logic                r_fs;
  logic [PTR_W-1:0]    r_src;
  logic                r_busy;

  logic                w_win_vld;
  logic [PTR_W-1:0]    w_win;
  logic [PTR_W-1:0]    w_cand;
  int                  w_idx;
  logic                w_grant;
  logic [DATA_W-1:0]   w_win_dat;
  logic                w_last_bit;
  logic                w_gap_done;

  // Search upward from r_ptr with wrap; the first valid requester wins.
  always_comb begin
    w_win_vld = 1'b0;
    w_win     = '0;
    w_cand    = '0;
    w_idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx  = (int'(r_ptr) + k) % NUM_REQ;
      w_cand = PTR_W'(w_idx);
      if (!w_win_vld && bus.req_valid[w_cand]) begin
        w_win_vld = 1'b1;
        w_win     = w_cand;
      end
    end
  end

  assign w_grant       = w_win_vld && (r_state == ST_IDLE);
  assign bus.req_ready = (w_grant && reset_n) ? (NUM_REQ'(1) << w_win) : '0;
  assign w_win_dat     = bus.req_data[w_win*DATA_W +: DATA_W];
  assign w_last_bit    = (r_cnt == CNT_W'(DATA_W - 1));
  assign w_gap_done    = (r_gap_cnt == 4'(IDLE_GAP - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_grant) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last_bit) w_state_nxt = (IDLE_GAP > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (w_gap_done) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_gap_cnt <= '0;
      r_shift   <= '0;
      r_so      <= 1'b0;
      r_bv      <= 1'b0;
      r_fs      <= 1'b0;
      r_src     <= '0;
      r_busy    <= 1'b0;
    end else begin
      // busy mirrors the state register, so it follows the next state
      r_busy <= (w_state_nxt != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_shift <= w_win_dat;
            r_so    <= w_win_dat[0];
            r_bv    <= 1'b1;
            r_fs    <= 1'b1;
            r_src   <= w_win;
            r_cnt   <= '0;
            // explicit wrap keeps non-power-of-2 requester counts in range
            r_ptr   <= (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
          end
        end
        ST_SHIFT: begin
          r_fs <= 1'b0;
          if (w_last_bit) begin
            r_bv      <= 1'b0;
            r_so      <= 1'b0;
            r_gap_cnt <= '0;
          end else begin
            r_shift <= r_shift >> 1;
            r_so    <= r_shift[1];
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        ST_GAP: r_gap_cnt <= r_gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.serialOut   = r_so;
  assign bus.bit_valid   = r_bv;
  assign bus.frame_start = r_fs;
  assign bus.frame_src   = r_src;
  assign bus.busy        = r_busy;
endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Purpose : directed bench for serial_tx_scheduler (gap 0 and gap 3 instances).
// Latency : n/a.
// Backpressure: requesters hold valid until req_ready, as the scheduler expects.
module tb_serial_tx_scheduler;
  logic clock;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   g_cyc = 0;

  serial_tx_scheduler_if #(.NUM_REQ(4), .DATA_W(8)) bus_a ();
  serial_tx_scheduler_if #(.NUM_REQ(4), .DATA_W(8)) bus_b ();

  serial_tx_scheduler #(.NUM_REQ(4), .DATA_W(8), .IDLE_GAP(0)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a));
  serial_tx_scheduler #(.NUM_REQ(4), .DATA_W(8), .IDLE_GAP(3)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(bus_b));

  logic [9:0] obs_a;
  logic [9:0] obs_b;
  assign obs_a = {bus_a.serialOut, bus_a.bit_valid, bus_a.frame_start, bus_a.frame_src, bus_a.busy, bus_a.req_ready};
  assign obs_b = {bus_b.serialOut, bus_b.bit_valid, bus_b.frame_start, bus_b.frame_src, bus_b.busy, bus_b.req_ready};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [1:0]  exp_w;
    logic [7:0]  exp_d;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Enter at a negedge with inputs applied; leave at the negedge of the post-frame IDLE cycle.
  task automatic serve(input logic [1:0] w, input logic [7:0] d, input bit drop);
    int waited;
    waited = 0;
    #1;
    while (bus_a.req_ready == 4'b0 && waited < 40) begin
      @(negedge clock);
      #1;
      waited++;
    end
    chk("grant_rdy", 32'(bus_a.req_ready), 32'(4'b1 << w));
    @(posedge clock);
    #1;
    g_cyc = cyc;
    if (drop) bus_a.req_valid = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk("frame_bit", 32'(obs_a), 32'({d[k], 1'b1, (k == 0), w, 1'b1, 4'b0000}));
    end
    @(negedge clock);
    chk("frame_tail", 32'({bus_a.serialOut, bus_a.bit_valid, bus_a.busy}), 32'(3'b000));
  endtask

  initial begin
    int prev;
    int busy_cnt;
    logic [7:0] db;

    vecs[0] = '{4'b0001, 32'h000000A5, 2'd0, 8'hA5};
    vecs[1] = '{4'b1111, 32'h08040201, 2'd1, 8'h02};
    vecs[2] = '{4'b1111, 32'h08040201, 2'd2, 8'h04};
    vecs[3] = '{4'b1111, 32'h08040201, 2'd3, 8'h08};
    vecs[4] = '{4'b1111, 32'h08040201, 2'd0, 8'h01};
    vecs[5] = '{4'b0100, 32'h003C0000, 2'd2, 8'h3C};
    vecs[6] = '{4'b1001, 32'h5A0000C3, 2'd3, 8'h5A};
    vecs[7] = '{4'b0001, 32'h5A0000C3, 2'd0, 8'hC3};
    vecs[8] = '{4'b0110, 32'h007E8100, 2'd1, 8'h81};

    // reset state, with requests pending to show req_ready is masked
    reset_n = 1'b0;
    bus_a.req_valid = 4'b1111; bus_a.req_data = 32'h08040201;
    bus_b.req_valid = 4'b1111; bus_b.req_data = 32'h08040201;
    #1;
    chk("rst_state_a", 32'(obs_a), 32'(0));
    chk("rst_state_b", 32'(obs_b), 32'(0));
    @(negedge clock);
    @(negedge clock);
    bus_a.req_valid = '0;
    bus_b.req_valid = '0;
    reset_n = 1'b1;

    // single-frame vectors; round-robin pointer carries across them
    for (int i = 0; i < 9; i++) begin
      bus_a.req_valid = vecs[i].valid;
      bus_a.req_data  = vecs[i].data;
      serve(vecs[i].exp_w, vecs[i].exp_d, 1'b1);
    end

    // requester 1 pulses valid while a frame shifts: never accepted
    bus_a.req_valid = 4'b0001; bus_a.req_data = 32'h00000011;
    #1;
    chk("wd_grant0", 32'(bus_a.req_ready), 32'(4'b0001));
    @(posedge clock);
    #1;
    bus_a.req_valid = '0;
    for (int c = 0; c < 13; c++) begin
      @(negedge clock);
      if (c == 2) begin bus_a.req_valid = 4'b0010; bus_a.req_data = 32'h0000EE00; end
      if (c == 5) bus_a.req_valid = '0;
      #1;
      chk("wd_no_ready", 32'(bus_a.req_ready), 32'(0));
    end
    chk("wd_idle", 32'(obs_a), 32'(0));

    // reset during bit 4 of 8'hFF
    @(negedge clock);
    bus_a.req_valid = 4'b0001; bus_a.req_data = 32'h000000FF;
    #1;
    chk("mr_grant", 32'(bus_a.req_ready), 32'(4'b0001));
    @(posedge clock);
    #1;
    bus_a.req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("mr_bit", 32'(obs_a), 32'({1'b1, 1'b1, (k == 0), 2'd0, 1'b1, 4'b0000}));
    end
    reset_n = 1'b0;
    bus_a.req_valid = 4'b1111; bus_a.req_data = 32'h08040201;
    #1;
    chk("mr_async_clear", 32'(obs_a), 32'(0));
    @(negedge clock);
    chk("mr_no_bits", 32'(obs_a), 32'(0));
    reset_n = 1'b1;
    #1;
    chk("mr_tie_req0", 32'(obs_a), 32'(10'b0000000001));

    // contention right after reset: 0,1,2,3,0 at 9-cycle spacing, full frames
    serve(2'd0, 8'h01, 1'b0);
    prev = g_cyc;
    for (int n = 1; n < 5; n++) begin
      serve(2'(n % 4), 8'(1 << (n % 4)), 1'b0);
      chk("cont_spacing", 32'(g_cyc - prev), 32'(9));
      prev = g_cyc;
    end
    bus_a.req_valid = '0;

    // IDLE_GAP=3 instance, requester 2 holds valid continuously
    db = 8'h96;
    bus_b.req_valid = 4'b0100; bus_b.req_data = 32'h00960000;
    #1;
    chk("gap_first_rdy", 32'(bus_b.req_ready), 32'(4'b0100));
    @(posedge clock);
    #1;
    prev = cyc;
    for (int p = 0; p < 2; p++) begin
      busy_cnt = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clock);
        busy_cnt += int'(bus_b.busy);
        if (c < 8) chk("gap_bit", 32'({bus_b.serialOut, bus_b.bit_valid, bus_b.frame_src}), 32'({db[c], 1'b1, 2'd2}));
        else       chk("gap_quiet", 32'({bus_b.serialOut, bus_b.bit_valid}), 32'(2'b00));
        if (c == 11) chk("gap_rdy", 32'(bus_b.req_ready), 32'(4'b0100));
      end
      chk("gap_busy_cnt", 32'(busy_cnt), 32'(11));
      @(posedge clock);
      #1;
      chk("gap_spacing", 32'(cyc - prev), 32'(12));
      prev = cyc;
    end
    bus_b.req_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
